// File: rtl/password_controller_if.sv
// ---------------------------------------------------------------------------
// password_controller_if
// Groups the password controller's login and ROM-side signals into one bundle.
//   master : drives pass_allow, address_user, pw_input, pw_enter and q_pw.
//            This side is the upstream user-ID stage, the keypad and the ROM.
//            It observes address_pw and the login status outputs.
//   slave  : the password controller itself (consumes the inputs above,
//            drives address_pw, login_ok, pw_fail, lockout, tries_left)
// ---------------------------------------------------------------------------
interface password_controller_if #(
  parameter int PW_W   = 16,
  parameter int ADDR_W = 3
);
  logic              pass_allow;
  logic [ADDR_W-1:0] address_user;
  logic [PW_W-1:0]   pw_input;
  logic              pw_enter;
  logic [PW_W-1:0]   q_pw;
  logic [ADDR_W-1:0] address_pw;
  logic              login_ok;
  logic              pw_fail;
  logic              lockout;
  logic [2:0]        tries_left;

  modport master (
    output pass_allow, address_user, pw_input, pw_enter, q_pw,
    input  address_pw, login_ok, pw_fail, lockout, tries_left
  );

  modport slave (
    input  pass_allow, address_user, pw_input, pw_enter, q_pw,
    output address_pw, login_ok, pw_fail, lockout, tries_left
  );
endinterface

// File: rtl/password_controller.sv
// ---------------------------------------------------------------------------
// password_controller
// Second login stage. Once the user-ID stage raises pass_allow, the matched
// user index is latched as the password ROM address. Each entered password
// is then compared with the stored one, after waiting out the ROM read
// latency. A match grants login. MAX_TRIES mismatches lock the session.
// Ports:
//   clk  - rising-edge system clock
//   rst  - synchronous active-high reset
//   bus  - password_controller_if.slave
//          inputs : pass_allow, address_user, pw_input, pw_enter, q_pw
//          outputs: address_pw, login_ok (sticky), pw_fail (1-clk pulse),
//                   lockout (sticky), tries_left (3 bits)
// ---------------------------------------------------------------------------
module password_controller #(
  parameter int PW_W        = 16,
  parameter int ADDR_W      = 3,
  parameter int MAX_TRIES   = 3,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  password_controller_if.slave  bus
);

  // The wait counter only has to reach ROM_LATENCY-1.
  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROM_LATENCY - 1);
  localparam logic [2:0]       TRIES_INIT = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_GRANT   = 3'd4,
    ST_LOCKED  = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] address_pw_r, address_pw_nxt_s;
  logic              login_ok_r, login_ok_nxt_s;
  logic              pw_fail_r, pw_fail_nxt_s;
  logic              lockout_r, lockout_nxt_s;
  logic [2:0]        tries_left_r, tries_left_nxt_s;
  logic [PW_W-1:0]   pw_reg_r, pw_reg_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;

  // State and output registers, with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      address_pw_r <= '0;
      login_ok_r   <= 1'b0;
      pw_fail_r    <= 1'b0;
      lockout_r    <= 1'b0;
      tries_left_r <= TRIES_INIT;
      pw_reg_r     <= '0;
      cnt_r        <= '0;
    end else begin
      state_r      <= state_nxt_s;
      address_pw_r <= address_pw_nxt_s;
      login_ok_r   <= login_ok_nxt_s;
      pw_fail_r    <= pw_fail_nxt_s;
      lockout_r    <= lockout_nxt_s;
      tries_left_r <= tries_left_nxt_s;
      pw_reg_r     <= pw_reg_nxt_s;
      cnt_r        <= cnt_nxt_s;
    end
  end

  // Next-state and next-output logic.
  // Everything holds by default, except pw_fail, which is a single-cycle pulse.
  always_comb begin
    state_nxt_s      = state_r;
    address_pw_nxt_s = address_pw_r;
    login_ok_nxt_s   = login_ok_r;
    pw_fail_nxt_s    = 1'b0;
    lockout_nxt_s    = lockout_r;
    tries_left_nxt_s = tries_left_r;
    pw_reg_nxt_s     = pw_reg_r;
    cnt_nxt_s        = cnt_r;

    case (state_r)
      ST_IDLE: begin
        // A pw_enter arriving in the same cycle as pass_allow is dropped.
        if (bus.pass_allow) begin
          address_pw_nxt_s = bus.address_user;
          tries_left_nxt_s = TRIES_INIT;
          state_nxt_s      = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ARMED: begin
        if (bus.pw_enter) begin
          pw_reg_nxt_s = bus.pw_input;
          cnt_nxt_s    = '0;
          state_nxt_s  = ST_WAIT;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end

      ST_WAIT: begin
        // address_pw has been stable since ARMED.
        // Together with the COMPARE cycle, this counts out the ROM latency.
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_COMPARE;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          state_nxt_s = ST_WAIT;
        end
      end

      ST_COMPARE: begin
        if (bus.q_pw == pw_reg_r) begin
          login_ok_nxt_s = 1'b1;
          state_nxt_s    = ST_GRANT;
        end else if (tries_left_r > 3'd1) begin
          tries_left_nxt_s = tries_left_r - 3'd1;
          pw_fail_nxt_s    = 1'b1;
          state_nxt_s      = ST_ARMED;
        end else begin
          // The final failure locks the session and does not pulse pw_fail.
          tries_left_nxt_s = 3'd0;
          lockout_nxt_s    = 1'b1;
          state_nxt_s      = ST_LOCKED;
        end
      end

      ST_GRANT: begin
        state_nxt_s = ST_GRANT;
      end

      ST_LOCKED: begin
        state_nxt_s = ST_LOCKED;
      end

      default: begin
        // Unreachable encodings fall back to a safe idle.
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign bus.address_pw = address_pw_r;
  assign bus.login_ok   = login_ok_r;
  assign bus.pw_fail    = pw_fail_r;
  assign bus.lockout    = lockout_r;
  assign bus.tries_left = tries_left_r;

endmodule

// File: tb/tb_password_controller.sv
// ---------------------------------------------------------------------------
// tb_password_controller
// Self-checking bench for password_controller.
// The main instance (ROM_LATENCY=2, MAX_TRIES=3) is driven from a
// cycle-by-cycle vector table.
// Two sweep instances are driven by a hand-written sequence:
//   - ROM_LATENCY=1, MAX_TRIES=1
//   - ROM_LATENCY=4, MAX_TRIES=1
// ---------------------------------------------------------------------------
module tb_password_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  password_controller_if #(.PW_W(16), .ADDR_W(3)) bus0 ();
  password_controller_if #(.PW_W(16), .ADDR_W(3)) bus1 ();
  password_controller_if #(.PW_W(16), .ADDR_W(3)) bus4 ();

  password_controller #(.PW_W(16), .ADDR_W(3), .MAX_TRIES(3), .ROM_LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  password_controller #(.PW_W(16), .ADDR_W(3), .MAX_TRIES(1), .ROM_LATENCY(1)) dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  password_controller #(.PW_W(16), .ADDR_W(3), .MAX_TRIES(1), .ROM_LATENCY(4)) dut_l4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus plus the outputs expected after its edge.
  typedef struct {
    logic        rst;
    logic        pa;
    logic [2:0]  au;
    logic [15:0] pi;
    logic        pe;
    logic [15:0] q;
    logic [2:0]  ap;
    logic        ok;
    logic        pf;
    logic        lk;
    logic [2:0]  tl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic pa, input logic [2:0] au,
                     input logic [15:0] pi, input logic pe, input logic [15:0] q,
                     input logic [2:0] ap, input logic ok, input logic pf,
                     input logic lk, input logic [2:0] tl);
    vec_t v;
    v.rst = r;  v.pa = pa; v.au = au; v.pi = pi; v.pe = pe; v.q = q;
    v.ap  = ap; v.ok = ok; v.pf = pf; v.lk = lk; v.tl = tl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Runs the two sweep instances side by side through one attempt.
  // Both instances see the same strobe; each gets its own q_pw.
  // Results are expected on edges strobe+2 (latency 1) and strobe+5 (latency 4).
  task automatic sweep(input int tag, input logic [15:0] q1, input logic [15:0] q4,
                       input logic good1, input logic good4);
    logic d1;
    logic d4;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.pass_allow = 1'b1; bus1.address_user = 3'd2; bus1.q_pw = q1;
    bus4.pass_allow = 1'b1; bus4.address_user = 3'd2; bus4.q_pw = q4;
    @(posedge clk); #1;
    chk("sweep_l1_addr", tag, 16'(bus1.address_pw), 16'd2);
    chk("sweep_l4_addr", tag, 16'(bus4.address_pw), 16'd2);
    chk("sweep_l1_tries_init", tag, 16'(bus1.tries_left), 16'd1);
    chk("sweep_l4_tries_init", tag, 16'(bus4.tries_left), 16'd1);
    bus1.pw_input = 16'h5A5A; bus1.pw_enter = 1'b1;
    bus4.pw_input = 16'h5A5A; bus4.pw_enter = 1'b1;
    @(posedge clk); #1;
    bus1.pw_enter = 1'b0;
    bus4.pw_enter = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      d1 = (k >= 2);
      d4 = (k >= 5);
      chk("sweep_l1_login_ok", tag * 10 + k, 16'(bus1.login_ok), 16'(d1 & good1));
      chk("sweep_l1_lockout",  tag * 10 + k, 16'(bus1.lockout),  16'(d1 & ~good1));
      chk("sweep_l1_pw_fail",  tag * 10 + k, 16'(bus1.pw_fail),  16'd0);
      chk("sweep_l1_tries",    tag * 10 + k, 16'(bus1.tries_left),
          (d1 && !good1) ? 16'd0 : 16'd1);
      chk("sweep_l4_login_ok", tag * 10 + k, 16'(bus4.login_ok), 16'(d4 & good4));
      chk("sweep_l4_lockout",  tag * 10 + k, 16'(bus4.lockout),  16'(d4 & ~good4));
      chk("sweep_l4_pw_fail",  tag * 10 + k, 16'(bus4.pw_fail),  16'd0);
      chk("sweep_l4_tries",    tag * 10 + k, 16'(bus4.tries_left),
          (d4 && !good4) ? 16'd0 : 16'd1);
    end
    bus1.pass_allow = 1'b0;
    bus4.pass_allow = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus0.pass_allow = 1'b0; bus0.address_user = 3'd0; bus0.pw_input = 16'h0000;
    bus0.pw_enter = 1'b0; bus0.q_pw = 16'h0000;
    bus1.pass_allow = 1'b0; bus1.address_user = 3'd0; bus1.pw_input = 16'h0000;
    bus1.pw_enter = 1'b0; bus1.q_pw = 16'h0000;
    bus4.pass_allow = 1'b0; bus4.address_user = 3'd0; bus4.pw_input = 16'h0000;
    bus4.pw_enter = 1'b0; bus4.q_pw = 16'h0000;

    // Each add() argument list is:
    //   count, then inputs (rst pa au pi pe q),
    //   then expected outputs (address_pw login_ok pw_fail lockout tries_left).

    // Reset, arm user 3, correct password: login_ok three edges after the strobe.
    add(1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd3, 16'h0000, 1'b0, 16'h1234, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b1, 16'h1234, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h1234, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3);
    // Reset after GRANT.
    add(1, 1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    // Two failures, then success. pass_allow stays high throughout.
    add(1, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd2, 16'h0001, 1'b1, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd2, 16'h0001, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd2, 16'h0001, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b1, 1'b0, 3'd2);
    add(1, 1'b0, 1'b1, 3'd2, 16'h0002, 1'b1, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2);
    add(2, 1'b0, 1'b1, 3'd2, 16'h0002, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2);
    add(1, 1'b0, 1'b1, 3'd2, 16'h0002, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b1, 1'b0, 3'd1);
    add(1, 1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b1, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd1);
    add(2, 1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b0, 3'd1);
    add(1, 1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 16'hBEEF, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1);
    // address_user changes after arming must not move address_pw.
    add(1, 1'b0, 1'b1, 3'd7, 16'hBEEF, 1'b0, 16'hBEEF, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1);
    // Strobes in IDLE and in the arming cycle are dropped.
    // A strobe during WAIT is ignored; only the 16'h1111 captured in ARMED counts.
    add(1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b0, 3'd0, 16'hBEEF, 1'b1, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd6, 16'hBEEF, 1'b1, 16'hBEEF, 3'd6, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd6, 16'h1111, 1'b1, 16'hBEEF, 3'd6, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd6, 16'hBEEF, 1'b1, 16'hBEEF, 3'd6, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd6, 16'hBEEF, 1'b0, 16'hBEEF, 3'd6, 1'b0, 1'b1, 1'b0, 3'd2);
    add(1, 1'b0, 1'b1, 3'd6, 16'hBEEF, 1'b0, 16'hBEEF, 3'd6, 1'b0, 1'b0, 1'b0, 3'd2);
    // Three failures give lockout; a later correct entry is ignored.
    // The third entry is only one bit off.
    add(1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b1, 1'b0, 3'd2);
    add(1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2);
    add(2, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2);
    add(1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b1, 1'b0, 3'd1);
    add(1, 1'b0, 1'b1, 3'd1, 16'hA5A4, 1'b1, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    add(2, 1'b0, 1'b1, 3'd1, 16'hA5A4, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    add(1, 1'b0, 1'b1, 3'd1, 16'hA5A4, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b1, 3'd0);
    add(1, 1'b0, 1'b1, 3'd1, 16'hA5A5, 1'b1, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b1, 3'd0);
    add(4, 1'b0, 1'b1, 3'd1, 16'hA5A5, 1'b0, 16'hA5A5, 3'd1, 1'b0, 1'b0, 1'b1, 3'd0);
    // Reset while in WAIT abandons the attempt; then re-arm with user 5.
    add(1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd4, 16'h0000, 1'b0, 16'hA5A5, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd4, 16'hA5A5, 1'b1, 16'hA5A5, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b1, 1'b1, 3'd4, 16'hA5A5, 1'b0, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(3, 1'b0, 1'b0, 3'd4, 16'hA5A5, 1'b0, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd5, 16'hA5A5, 1'b0, 16'hA5A5, 3'd5, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd5, 16'hA5A5, 1'b1, 16'hA5A5, 3'd5, 1'b0, 1'b0, 1'b0, 3'd3);
    add(2, 1'b0, 1'b1, 3'd5, 16'hA5A5, 1'b0, 16'hA5A5, 3'd5, 1'b0, 1'b0, 1'b0, 3'd3);
    add(1, 1'b0, 1'b1, 3'd5, 16'hA5A5, 1'b0, 16'hA5A5, 3'd5, 1'b1, 1'b0, 1'b0, 3'd3);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst               = vecs[i].rst;
      bus0.pass_allow   = vecs[i].pa;
      bus0.address_user = vecs[i].au;
      bus0.pw_input     = vecs[i].pi;
      bus0.pw_enter     = vecs[i].pe;
      bus0.q_pw         = vecs[i].q;
      @(posedge clk); #1;
      chk("address_pw", i, 16'(bus0.address_pw), 16'(vecs[i].ap));
      chk("login_ok",   i, 16'(bus0.login_ok),   16'(vecs[i].ok));
      chk("pw_fail",    i, 16'(bus0.pw_fail),    16'(vecs[i].pf));
      chk("lockout",    i, 16'(bus0.lockout),    16'(vecs[i].lk));
      chk("tries_left", i, 16'(bus0.tries_left), 16'(vecs[i].tl));
    end

    // Parameter sweep: latency 1 and 4, single try.
    sweep(1, 16'h5A5A, 16'h5A5B, 1'b1, 1'b0);
    sweep(2, 16'h0000, 16'h5A5A, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
